// File: rtl/ram_io_responder.sv
// Byte-serial RAM bus responder: synchronous byte RAM plus a small
// memory-mapped IO window with TX/RX byte FIFOs and a program-end register.
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ram_rw_select_in,
  input  logic [31:0] ram_addr_in,
  input  logic [7:0]  ram_data_in,
  output logic [7:0]  ram_data_out,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        program_end,
  output logic [7:0]  end_code
);

  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  localparam logic [TW:0] TX_FULL = (TW+1)'(TX_DEPTH);
  localparam logic [TW:0] TX_THR  = (TW+1)'(TX_DEPTH - 2);
  localparam logic [RW:0] RX_FULL = (RW+1)'(RX_DEPTH);

  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [7:0]    tx_mem [TX_DEPTH];
  logic [TW-1:0] tx_rd;
  logic [TW-1:0] tx_wr;
  logic [TW:0]   tx_cnt;

  logic [7:0]    rx_mem [RX_DEPTH];
  logic [RW-1:0] rx_rd;
  logic [RW-1:0] rx_wr;
  logic [RW:0]   rx_cnt;

  logic        prev_rw;
  logic [31:0] prev_addr;

  logic       is_io;
  logic       sel_tx;
  logic       sel_st;
  logic       new_acc;
  logic       tx_full;
  logic       tx_pop;
  logic       tx_req;
  logic       tx_push;
  logic       tx_drop;
  logic       rx_pop;
  logic       rx_push;
  logic       end_wr;
  logic [7:0] io_rdata;

  always_comb begin
    is_io   = ram_addr_in[17:16] == 2'b11;
    sel_tx  = is_io && (ram_addr_in[15:0] == 16'h0000);
    sel_st  = is_io && (ram_addr_in[15:0] == 16'h0004);
    // Controller idles on its last address; only a change is a fresh access.
    new_acc = {ram_rw_select_in, ram_addr_in} != {prev_rw, prev_addr};
    tx_full = tx_cnt == TX_FULL;
    tx_pop  = tx_valid && tx_ready;
    tx_req  = ram_rw_select_in && sel_tx && new_acc;
    tx_push = tx_req && (!tx_full || tx_pop);
    tx_drop = tx_req && tx_full && !tx_pop;
    rx_pop  = !ram_rw_select_in && sel_tx && new_acc && (rx_cnt != '0);
    rx_push = rx_valid && (rx_ready || rx_pop);
    end_wr  = ram_rw_select_in && sel_st && new_acc;
  end

  always_comb begin
    io_rdata = 8'h00;
    if (sel_tx) begin
      if (!new_acc)
        io_rdata = ram_data_out;
      else if (rx_cnt != '0)
        io_rdata = rx_mem[rx_rd];
    end else if (sel_st) begin
      io_rdata = {6'b0, ~rx_ready, tx_valid};
    end
  end

  assign tx_valid       = tx_cnt != '0;
  assign tx_data        = tx_mem[tx_rd];
  assign io_buffer_full = tx_cnt >= TX_THR;
  assign rx_ready       = rx_cnt != RX_FULL;

  always_ff @(posedge clk) begin
    if (rdy && !rst && ram_rw_select_in && !is_io)
      mem[ram_addr_in[ADDR_WIDTH-1:0]] <= ram_data_in;
  end

  always_ff @(posedge clk) begin
    if (rdy && !rst && tx_push)
      tx_mem[tx_wr] <= ram_data_in;
    if (rdy && !rst && rx_push)
      rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_data_out <= 8'h00;
      prev_rw      <= 1'b1;
      prev_addr    <= '1;
      tx_overflow  <= 1'b0;
      program_end  <= 1'b0;
      end_code     <= 8'h00;
    end else if (rdy) begin
      prev_rw   <= ram_rw_select_in;
      prev_addr <= ram_addr_in;
      if (!ram_rw_select_in) begin
        if (is_io)
          ram_data_out <= io_rdata;
        else
          ram_data_out <= mem[ram_addr_in[ADDR_WIDTH-1:0]];
      end
      if (tx_drop)
        tx_overflow <= 1'b1;
      if (end_wr) begin
        program_end <= 1'b1;
        end_code    <= ram_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
    end else if (rdy) begin
      if (tx_push)
        tx_wr <= tx_wr + 1'b1;
      if (tx_pop)
        tx_rd <= tx_rd + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else if (rdy) begin
      if (rx_push)
        rx_wr <= rx_wr + 1'b1;
      if (rx_pop)
        rx_rd <= rx_rd + 1'b1;
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM path, TX/RX FIFOs, status
// register, program-end, rdy stall and mid-run reset.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rw;
  logic [31:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        buf_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        tx_overflow;
  logic        program_end;
  logic [7:0]  end_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_io_responder dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .ram_rw_select_in (rw),
    .ram_addr_in      (addr),
    .ram_data_in      (din),
    .ram_data_out     (dout),
    .io_buffer_full   (buf_full),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .tx_overflow      (tx_overflow),
    .program_end      (program_end),
    .end_code         (end_code)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  din;
    bit          chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic r, input logic [31:0] a, input logic [7:0] d);
    rw   = r;
    addr = a;
    din  = d;
    cyc();
  endtask

  task automatic tx_push(input logic [7:0] d);
    bus(1'b1, 32'h30000, d);
    bus(1'b0, 32'h0, 8'h00);
  endtask

  logic [7:0] rx_exp [5];

  initial begin
    vt[0]  = '{1'b1, 32'h0000_0100, 8'hAA, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 32'h0000_0101, 8'hBB, 1'b0, 8'h00};
    vt[2]  = '{1'b1, 32'h0000_0102, 8'hCC, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 32'h0000_0103, 8'hDD, 1'b0, 8'h00};
    vt[4]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'hAA};
    vt[5]  = '{1'b0, 32'h0000_0101, 8'h00, 1'b1, 8'hBB};
    vt[6]  = '{1'b0, 32'h0000_0102, 8'h00, 1'b1, 8'hCC};
    vt[7]  = '{1'b0, 32'h0000_0103, 8'h00, 1'b1, 8'hDD};
    vt[8]  = '{1'b1, 32'h0001_FFFF, 8'h5A, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h5A};
    vt[10] = '{1'b0, 32'h0020_0101, 8'h00, 1'b1, 8'hBB};
    vt[11] = '{1'b1, 32'h0003_0008, 8'h99, 1'b0, 8'h00};
    vt[12] = '{1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h00};
    vt[13] = '{1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h00};

    rst = 1'b1; rdy = 1'b1; rw = 1'b0; addr = 32'h0; din = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_dout", dout, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_buf_full", buf_full, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_overflow", tx_overflow, 1'b0);
    check("rst_prog_end", program_end, 1'b0);
    check("rst_end_code", end_code, 8'h00);

    for (int i = 0; i < 14; i++) begin
      bus(vt[i].rw, vt[i].addr, vt[i].din);
      if (vt[i].chk)
        check($sformatf("vec%0d", i), dout, vt[i].exp);
    end
    check("io_wr_ignored", tx_valid, 1'b0);

    // Held IO store must push exactly once.
    rw = 1'b1; addr = 32'h30000; din = 8'h41;
    repeat (5) cyc();
    bus(1'b0, 32'h0, 8'h00);
    check("hold_tx_valid", tx_valid, 1'b1);
    check("hold_tx_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check("hold_one_entry", tx_valid, 1'b0);

    for (int i = 1; i <= 9; i++) begin
      tx_push(8'(8'h60 + i));
      if (i <= 8)
        check($sformatf("buf_full_%0d", i), buf_full, i >= 6);
      if (i >= 8)
        check($sformatf("overflow_%0d", i), tx_overflow, i == 9);
    end
    check("tx_head_after_fill", tx_data, 8'h61);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain_valid_%0d", k), tx_valid, 1'b1);
      check($sformatf("drain_data_%0d", k), tx_data, 8'(8'h60 + k));
      cyc();
    end
    tx_ready = 1'b0;
    check("drain_empty", tx_valid, 1'b0);
    check("overflow_sticky", tx_overflow, 1'b1);

    rx_valid = 1'b1; rx_data = 8'h10; cyc();
    rx_data = 8'h20; cyc();
    rx_valid = 1'b0;
    bus(1'b0, 32'h30000, 8'h00);
    check("rx_read_1", dout, 8'h10);
    bus(1'b0, 32'h0, 8'h00);
    bus(1'b0, 32'h30000, 8'h00);
    check("rx_read_2", dout, 8'h20);
    bus(1'b0, 32'h0, 8'h00);
    bus(1'b0, 32'h30000, 8'h00);
    check("rx_read_empty", dout, 8'h00);
    bus(1'b0, 32'h0, 8'h00);

    rx_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      rx_data = 8'(8'hA0 + i);
      cyc();
      if (i >= 3)
        check($sformatf("rx_ready_%0d", i), rx_ready, i < 4);
    end
    rx_valid = 1'b0;
    bus(1'b0, 32'h30004, 8'h00);
    check("status_rx_full", dout, 8'h02);
    rx_valid = 1'b1; rx_data = 8'hA6;
    bus(1'b0, 32'h30000, 8'h00);
    rx_valid = 1'b0;
    check("rx_full_pop", dout, 8'hA1);
    check("rx_full_push_kept", rx_ready, 1'b0);
    rx_exp[0] = 8'hA2; rx_exp[1] = 8'hA3; rx_exp[2] = 8'hA4;
    rx_exp[3] = 8'hA6; rx_exp[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 32'h0, 8'h00);
      bus(1'b0, 32'h30000, 8'h00);
      check($sformatf("rx_drain_%0d", i), dout, rx_exp[i]);
    end
    check("rx_ready_empty", rx_ready, 1'b1);

    bus(1'b1, 32'h30004, 8'h00);
    check("prog_end", program_end, 1'b1);
    check("end_code", end_code, 8'h00);
    tx_push(8'h55);
    bus(1'b0, 32'h30004, 8'h00);
    check("status_tx", dout, 8'h01);

    rdy = 1'b0; tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    rw = 1'b1; addr = 32'h100; din = 8'hEE;
    repeat (3) cyc();
    check("stall_tx_valid", tx_valid, 1'b1);
    check("stall_tx_data", tx_data, 8'h55);
    check("stall_dout", dout, 8'h01);
    rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    bus(1'b0, 32'h100, 8'h00);
    check("stall_ram", dout, 8'hAA);
    bus(1'b0, 32'h30000, 8'h00);
    check("stall_rx", dout, 8'h00);
    bus(1'b0, 32'h0, 8'h00);

    tx_push(8'h56);
    tx_push(8'h57);
    check("pre_rst_head", tx_data, 8'h55);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_prog_end", program_end, 1'b0);
    check("mid_rst_overflow", tx_overflow, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    cyc();
    check("post_rst_tx_valid", tx_valid, 1'b0);
    check("post_rst_rx_ready", rx_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
